// File: rtl/shift_ex_stage_if.sv
// shift_ex_stage_if: handshake bundle for the shift execute stage.
// Carries the upstream beat, the downstream result beat, the flush strobe
// and the forwarding copy of the result. The stage uses the slave modport
// and the environment driving it uses the master modport.
interface shift_ex_stage_if #(
    parameter int TAG_W = 3
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic [1:0]       in_op;
    logic [3:0]       in_shamt;
    logic [TAG_W-1:0] in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [TAG_W-1:0] out_rd;
    logic             fwd_valid;
    logic [TAG_W-1:0] fwd_rd;
    logic [15:0]      fwd_data;

    modport master (
        output flush, in_valid, in_data, in_op, in_shamt, in_rd, out_ready,
        input  in_ready, out_valid, out_data, out_rd, fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  flush, in_valid, in_data, in_op, in_shamt, in_rd, out_ready,
        output in_ready, out_valid, out_data, out_rd, fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/shift_ex_stage.sv
// shift_ex_stage: execute-stage slice for 16-bit shift/rotate instructions.
// One beat per cycle enters over a valid/ready handshake; the result and its
// destination tag are registered and presented on the output and forwarding
// ports. Optional macro SHIFT_SKID_EN adds a one-entry skid register so that
// in_ready comes straight from a flop instead of from out_ready.

// Combinational 16-bit shifter. Op: 00 rol, 01 sll, 10 ror, 11 sra.
module shifter_16b (
    input  logic [15:0] data,
    input  logic [1:0]  op,
    input  logic [3:0]  shamt,
    output logic [15:0] result
);
    logic [15:0] rol_w;
    logic [15:0] sll_w;
    logic [15:0] ror_w;
    logic [15:0] sra_w;

    // Each result bit selects its source bit; 4-bit index arithmetic wraps
    // modulo 16, which is exactly what the rotates need.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            localparam logic [3:0] IDX = 4'(gi);
            assign rol_w[gi] = data[IDX - shamt];
            assign ror_w[gi] = data[IDX + shamt];
            assign sll_w[gi] = (IDX >= shamt) ? data[IDX - shamt] : 1'b0;
            assign sra_w[gi] = (({1'b0, IDX} + {1'b0, shamt}) <= 5'd15) ?
                               data[IDX + shamt] : data[15];
        end
    endgenerate

    // Pick the operation's result.
    always_comb begin
        result = rol_w;
        case (op)
            2'b00:   result = rol_w;
            2'b01:   result = sll_w;
            2'b10:   result = ror_w;
            default: result = sra_w;
        endcase
    end
endmodule

module shift_ex_stage #(
    parameter int TAG_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    shift_ex_stage_if.slave    bus
);
    logic [15:0]      shift_result;
    logic             out_valid_reg;
    logic [15:0]      out_data_reg;
    logic [TAG_W-1:0] out_rd_reg;
    logic             load_en;
    logic             accept;
    logic             skid_valid_w;
    logic [15:0]      skid_data_w;
    logic [TAG_W-1:0] skid_rd_w;

    shifter_16b u_shifter (
        .data   (bus.in_data),
        .op     (bus.in_op),
        .shamt  (bus.in_shamt),
        .result (shift_result)
    );

    // The output register may take a new value when empty or when firing.
    assign load_en = !out_valid_reg || bus.out_ready;
    assign accept  = bus.in_valid && bus.in_ready;

`ifdef SHIFT_SKID_EN
    logic             skid_valid_reg;
    logic [15:0]      skid_data_reg;
    logic [TAG_W-1:0] skid_rd_reg;

    // Ready depends only on the skid flop, cutting the out_ready -> in_ready path.
    assign bus.in_ready = !skid_valid_reg;
    assign skid_valid_w = skid_valid_reg;
    assign skid_data_w  = skid_data_reg;
    assign skid_rd_w    = skid_rd_reg;

    // Skid entry: filled by a beat accepted while the output stalls, drained
    // into the output register on the next output load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_rd_reg    <= '0;
        end else if (bus.flush) begin
            skid_valid_reg <= 1'b0;
        end else if (load_en) begin
            skid_valid_reg <= 1'b0;
        end else if (accept) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= shift_result;
            skid_rd_reg    <= bus.in_rd;
        end
    end
`else
    // Without a skid entry the stage can only accept when the output can load.
    assign bus.in_ready = load_en;
    assign skid_valid_w = 1'b0;
    assign skid_data_w  = '0;
    assign skid_rd_w    = '0;
`endif

    // Output register: an older skid entry wins over the incoming beat so
    // ordering stays first-in first-out; flush squashes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_rd_reg    <= '0;
        end else if (bus.flush) begin
            out_valid_reg <= 1'b0;
        end else if (load_en) begin
            if (skid_valid_w) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= skid_data_w;
                out_rd_reg    <= skid_rd_w;
            end else begin
                out_valid_reg <= accept;
                if (accept) begin
                    out_data_reg <= shift_result;
                    out_rd_reg   <= bus.in_rd;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_rd    = out_rd_reg;
    assign bus.fwd_valid = out_valid_reg;
    assign bus.fwd_data  = out_data_reg;
    assign bus.fwd_rd    = out_rd_reg;
endmodule

// File: tb/tb_shift_ex_stage.sv
// tb_shift_ex_stage: randomized and directed bench for shift_ex_stage.
// The reference keeps the beats held by the stage as a queue and computes
// shift results with plain integer arithmetic.
module tb_shift_ex_stage;
    localparam int TAG_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shift_ex_stage_if #(.TAG_W(TAG_W)) bus ();

    shift_ex_stage #(.TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [TAG_W-1:0] rd;
        logic [15:0]      data;
    } beat_t;

    int    errors = 0;
    int    checks = 0;
    beat_t held[$];

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] op,
                                              input logic [3:0] s);
        longint x, p, q, r;
        x = longint'(d);
        p = 1;
        for (int i = 0; i < int'(s); i++) p = p * 2;
        q = 65536 / p;
        case (op)
            2'd0: r = x * p + x / q;
            2'd1: r = x * p;
            2'd2: r = x / p + x * q;
            default: begin
                if (x >= 32768) x = x - 65536;
                if (x < 0) r = -((-x + p - 1) / p);
                else       r = x / p;
            end
        endcase
        return 16'(r);
    endfunction

    function automatic bit exp_in_ready();
`ifdef SHIFT_SKID_EN
        return held.size() < 2;
`else
        return (held.size() == 0) || bus.out_ready;
`endif
    endfunction

    // Advance one clock and update the reference with what the stage should do.
    task automatic step();
        bit    acc;
        bit    fire;
        beat_t b;
        acc    = bus.in_valid && exp_in_ready();
        fire   = bus.out_ready && (held.size() > 0);
        b.rd   = bus.in_rd;
        b.data = ref_shift(bus.in_data, bus.in_op, bus.in_shamt);
        @(posedge clk);
        if (bus.flush) begin
            held.delete();
        end else begin
            if (fire) void'(held.pop_front());
            if (acc)  held.push_back(b);
        end
        #1;
    endtask

    task automatic set_in(input bit v, input logic [15:0] d, input logic [1:0] op,
                          input logic [3:0] s, input logic [TAG_W-1:0] rd);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_op    = op;
        bus.in_shamt = s;
        bus.in_rd    = rd;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0000", bus.out_data); end
        checks++; if (bus.out_rd !== '0) begin errors++; $display("FAIL rst_out_rd: got %0d want 0", bus.out_rd); end
        checks++; if (bus.fwd_valid !== 1'b0 || bus.fwd_data !== 16'h0 || bus.fwd_rd !== '0) begin
            errors++; $display("FAIL rst_fwd: got v=%b d=%h rd=%0d want zeros", bus.fwd_valid, bus.fwd_data, bus.fwd_rd); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        held.delete();
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %b want 0", bus.out_valid); end
        $display("reset: done");
    endtask

    task automatic test_ops();
        logic [15:0] vd [12];
        logic [1:0]  vo [12];
        logic [3:0]  vs [12];
        logic [15:0] ve [12];
        vd[0] = 16'h8001; vo[0] = 2'd0; vs[0] = 4'd1; ve[0] = 16'h0003;
        vd[1] = 16'h1234; vo[1] = 2'd1; vs[1] = 4'd4; ve[1] = 16'h2340;
        vd[2] = 16'h1234; vo[2] = 2'd2; vs[2] = 4'd4; ve[2] = 16'h4123;
        vd[3] = 16'h8000; vo[3] = 2'd3; vs[3] = 4'd4; ve[3] = 16'hF800;
        vd[4] = 16'hFFFF; vo[4] = 2'd1; vs[4] = 4'd15; ve[4] = 16'h8000;
        vd[5] = 16'h8000; vo[5] = 2'd3; vs[5] = 4'd15; ve[5] = 16'hFFFF;
        vd[6] = 16'h7FFF; vo[6] = 2'd3; vs[6] = 4'd15; ve[6] = 16'h0000;
        vd[7] = 16'h0001; vo[7] = 2'd2; vs[7] = 4'd1; ve[7] = 16'h8000;
        for (int i = 8; i < 12; i++) begin
            vd[i] = 16'($urandom); vo[i] = 2'(i - 8); vs[i] = 4'd0; ve[i] = vd[i];
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_in(1'b1, vd[i], vo[i], vs[i], TAG_W'(i));
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL op%0d_in_ready: got %b want 1", i, bus.in_ready); end
            step();
            set_in(1'b0, 16'h0, 2'd0, 4'd0, '0);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== ve[i] || bus.out_rd !== TAG_W'(i)) begin
                errors++; $display("FAIL op%0d_result: got v=%b d=%h rd=%0d want v=1 d=%h rd=%0d",
                                   i, bus.out_valid, bus.out_data, bus.out_rd, ve[i], TAG_W'(i)); end
            checks++; if (bus.fwd_data !== ve[i] || bus.fwd_valid !== 1'b1) begin
                errors++; $display("FAIL op%0d_fwd: got v=%b d=%h want v=1 d=%h", i, bus.fwd_valid, bus.fwd_data, ve[i]); end
            $display("op: in=%h op=%0d sh=%0d out=%h", vd[i], vo[i], vs[i], bus.out_data);
            step();
        end
    endtask

    task automatic test_streaming();
        logic [15:0]      e;
        logic [TAG_W-1:0] t;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 16'($urandom), 2'($urandom), 4'($urandom), TAG_W'($urandom));
            e = ref_shift(bus.in_data, bus.in_op, bus.in_shamt);
            t = bus.in_rd;
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream%0d_in_ready: got %b want 1", i, bus.in_ready); end
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== e || bus.out_rd !== t) begin
                errors++; $display("FAIL stream%0d: got v=%b d=%h rd=%0d want v=1 d=%h rd=%0d",
                                   i, bus.out_valid, bus.out_data, bus.out_rd, e, t); end
            $display("stream: beat %0d rd=%0d out=%h", i, bus.out_rd, bus.out_data);
        end
        set_in(1'b0, 16'h0, 2'd0, 4'd0, '0);
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_pressure();
        logic [15:0] d1, d2, e1, e2;
        d1 = 16'($urandom); d2 = 16'($urandom);
        e1 = ref_shift(d1, 2'd2, 4'd3);
        e2 = ref_shift(d2, 2'd3, 4'd5);
        bus.out_ready = 1'b0;
        set_in(1'b1, d1, 2'd2, 4'd3, TAG_W'(1));
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b want 1", bus.in_ready); end
        step();
        set_in(1'b1, d2, 2'd3, 4'd5, TAG_W'(2));
        #1;
`ifdef SHIFT_SKID_EN
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_second_ready: got %b want 1", bus.in_ready); end
`else
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_ready: got %b want 0", bus.in_ready); end
`endif
        step();
        checks++; if (bus.out_data !== e1 || bus.out_rd !== TAG_W'(1)) begin
            errors++; $display("FAIL bp_stall1: got d=%h rd=%0d want d=%h rd=1", bus.out_data, bus.out_rd, e1); end
`ifdef SHIFT_SKID_EN
        bus.in_valid = 1'b0;
`endif
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== e1 || bus.out_rd !== TAG_W'(1)) begin
            errors++; $display("FAIL bp_stall2: got v=%b d=%h rd=%0d want v=1 d=%h rd=1", bus.out_valid, bus.out_data, bus.out_rd, e1); end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== e2 || bus.out_rd !== TAG_W'(2)) begin
            errors++; $display("FAIL bp_second_out: got v=%b d=%h rd=%0d want v=1 d=%h rd=2", bus.out_valid, bus.out_data, bus.out_rd, e2); end
        $display("backpressure: rd=%0d out=%h after release", bus.out_rd, bus.out_data);
        set_in(1'b0, 16'h0, 2'd0, 4'd0, '0);
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        set_in(1'b1, 16'h1111, 2'd1, 4'd2, TAG_W'(3));
        step();
        set_in(1'b1, 16'h2222, 2'd0, 4'd1, TAG_W'(4));
        step();
        set_in(1'b1, 16'h3333, 2'd2, 4'd7, TAG_W'(5));
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        set_in(1'b0, 16'h0, 2'd0, 4'd0, '0);
        checks++; if (bus.out_valid !== 1'b0 || bus.fwd_valid !== 1'b0) begin
            errors++; $display("FAIL flush_valid: got out=%b fwd=%b want 0 0", bus.out_valid, bus.fwd_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost%0d: got %b want 0", i, bus.out_valid); end
        end
        $display("flush: squashed held and incoming beats");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            set_in(($urandom_range(0, 9) < 7), 16'($urandom), 2'($urandom), 4'($urandom), TAG_W'($urandom));
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 19) == 0);
            #1;
            checks++; if (bus.in_ready !== exp_in_ready()) begin
                errors++; $display("FAIL rnd%0d_in_ready: got %b want %b", i, bus.in_ready, exp_in_ready()); end
            step();
            checks++; if (bus.out_valid !== (held.size() > 0)) begin
                errors++; $display("FAIL rnd%0d_valid: got %b want %b", i, bus.out_valid, held.size() > 0); end
            else if (held.size() > 0) begin
                checks++; if (bus.out_data !== held[0].data || bus.out_rd !== held[0].rd) begin
                    errors++; $display("FAIL rnd%0d_data: got d=%h rd=%0d want d=%h rd=%0d",
                                       i, bus.out_data, bus.out_rd, held[0].data, held[0].rd); end
                $display("random: cycle %0d rd=%0d out=%h", i, bus.out_rd, bus.out_data);
            end
        end
        bus.flush = 1'b0;
        set_in(1'b0, 16'h0, 2'd0, 4'd0, '0);
        bus.out_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset_midstream();
        logic [15:0] e;
        bus.out_ready = 1'b0;
        set_in(1'b1, 16'hA5A5, 2'd0, 4'd9, TAG_W'(6));
        step();
        set_in(1'b0, 16'h0, 2'd0, 4'd0, '0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", bus.out_valid); end
        #2 rst = 1'b1;
        held.delete();
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.fwd_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_clear: got v=%b d=%h fwd=%b want 0 0000 0", bus.out_valid, bus.out_data, bus.fwd_valid); end
        #2 rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        set_in(1'b1, 16'h0F0F, 2'd1, 4'd4, TAG_W'(2));
        e = 16'hF0F0;
        #1;
        step();
        set_in(1'b0, 16'h0, 2'd0, 4'd0, '0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== e || bus.out_rd !== TAG_W'(2)) begin
            errors++; $display("FAIL midrst_first: got v=%b d=%h rd=%0d want v=1 d=%h rd=2", bus.out_valid, bus.out_data, bus.out_rd, e); end
        $display("reset midstream: first beat out=%h", bus.out_data);
        step();
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 16'h0, 2'd0, 4'd0, '0);
        test_reset();
        test_ops();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
